instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Packs decoded instruction fields (opcode, regs, funct, 32-bit immediate) into RV32I words and
//  streams them into instruction memory at consecutive word addresses. It is the inverse of
//  immediate extraction: it scatters imm bits into the I/S/B/J/U/R layouts selected by imm_sel.
//  It sits between the program loader/self-test sequencer and the IMEM write port.
// PARAMETERS
//  BASE_ADDR  32'h0  byte address of the first written word
//  DEPTH      256    max words per run; when reached, encoder reports full/done
//  AW         32     width of imem_addr
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   1-cycle pulse: begin run, reload address to BASE_ADDR, clear counters/flags
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   encoder accepts bundle this cycle
//  in_last    in   1   bundle is final of run
//  opcode     in   7   opcode[6:0]
//  imm_sel    in   3   000 I, 001 S, 010 B, 011 J, 100 U, 101 R (no imm)
//  rd,rs1,rs2 in   5   register fields (ignored where format has none)
//  funct3     in   3   funct3
//  funct7     in   7   funct7 (R only)
//  imm        in   32  signed immediate as byte value (B/J: offset; U: upper value incl. low 12 zeros)
//  imem_we    out  1   IMEM write strobe, one cycle per word
//  imem_addr  out  AW  IMEM byte address
//  imem_wdata out  32  encoded instruction
//  busy       out  1   state RUN or FLUSH
//  done       out  1   state DONE (level)
//  err        out  1   sticky: at least one bundle rejected (range check)
//  word_cnt   out  $clog2(DEPTH+1)  words written this run
// BEHAVIOUR
//  Reset: state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr = BASE_ADDR; wdata, word_cnt = 0.
//  FSM IDLE -start-> RUN; RUN -accept with in_last, or accept making word_cnt==DEPTH-> FLUSH;
//   FLUSH -(write retired)-> DONE; DONE -start-> RUN. start in RUN/FLUSH ignored.
//  in_ready = (state==RUN) && (word_cnt + pending < DEPTH). Accept = in_valid && in_ready.
//  Latency: bundle accepted at cycle N -> imem_we=1 with wdata/addr at N+1; back-to-back 1 word/cycle.
//  Address: first write at BASE_ADDR, +4 per write, wraps modulo 2^AW; word_cnt increments per write.
//  Encoding: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op};
//   U {imm[31:12],rd,op}; R {f7,rs2,rs1,f3,rd,op}; imm_sel 110/111 -> treated as rejected.
//  Rejected bundle: consumed (in_ready handshake completes), no write, address/word_cnt unchanged,
//   err set; in_last on a rejected bundle still ends run.
//  start during DONE clears err, word_cnt; reset mid-run aborts any pending write (imem_we=0 next edge).
// CONFIGURATION
//  ENCODER_RANGE_CHECK_EN defined: reject if imm not sign-representable in field width (I/S 12, B 13,
//   J 21), B/J imm[0]!=0, or U imm[11:0]!=0.
//  Not defined: no check, imm silently truncated to field bits, only illegal imm_sel rejected.
// STRUCTURE
//  Shared pkg/header: imm_sel encodings (IMM_I..IMM_R), opcode constants, FSM state encodings.
//  One sub-module: instr_pack (combinational field scatter + range-check result), instantiated once;
//  FSM, address counter, output register in top.
// TESTING
//  addi x1,x0,5 (op 0010011,I,imm 5) after start -> next cycle we=1, addr 0x0, wdata 0x00500093.
//  sw x2,8(x1) (S,f3 010) -> wdata 0x0020A423; beq x0,x0,-4 (B) -> 0xFE000EE3.
//  jal x1,8 (J) -> 0x008000EF; auipc x5,imm 0x12345000 (U) -> 0x12345297; 4 back-to-back -> addrs 0,4,8,C.
//  RANGE_CHECK_EN: addi imm 4096 -> no write, err=1, next valid bundle written at unchanged address.
//  DEPTH=4, stream 6 bundles no in_last -> 4 writes, in_ready low after 4th accept, done=1, word_cnt=4.
//  rst_n low one cycle after accept -> no imem_we, all outputs at reset values; start/in_last both paths.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   - imm_sel encodings (IMM_I .. IMM_R); 3'b110 and 3'b111 are illegal
//   - base opcode constants for the formats the encoder produces
//   - FSM state encoding used by the top level
//   - fits_signed(): two's-complement range test used by the optional
//     immediate range check (ENCODER_RANGE_CHECK_EN)
package instruction_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_R = 3'b101;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True when v, read as signed, survives truncation to w bits: every bit
  // from w-1 upward must be a copy of the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] hi;
    hi = $signed(v) >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// instr_pack: combinational field scatter for one decoded bundle.
// Places opcode/register/funct fields and the immediate bits into the
// RV32I I/S/B/J/U/R layout chosen by imm_sel_i and flags bundles that
// must not be written.
// Optional feature macro: ENCODER_RANGE_CHECK_EN (immediate range check).
// Ports:
//   opcode_i[6:0], imm_sel_i[2:0], rd_i/rs1_i/rs2_i[4:0], funct3_i[2:0],
//   funct7_i[6:0], imm_i[31:0]  -- decoded fields
//   word_o[31:0]                -- packed instruction word
//   reject_o                    -- bundle is illegal / out of range
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  imm_sel_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        reject_o
);

  always_comb begin
    word_o   = '0;
    reject_o = 1'b0;
    case (imm_sel_i)
      IMM_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
        reject_o = !fits_signed(imm_i, 12);
`endif
      end
      IMM_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
        reject_o = !fits_signed(imm_i, 12);
`endif
      end
      IMM_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
        // Branch offsets are halfword aligned; bit 0 has no slot.
        reject_o = !fits_signed(imm_i, 13) || imm_i[0];
`endif
      end
      IMM_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
        reject_o = !fits_signed(imm_i, 21) || imm_i[0];
`endif
      end
      IMM_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
        // The value is the upper immediate itself, so low 12 bits must be 0.
        reject_o = (imm_i[11:0] != 12'h000);
`endif
      end
      IMM_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      default: begin
        reject_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded instruction bundles into RV32I words
// and streams them to the instruction memory write port at consecutive
// word addresses starting at BASE_ADDR.
// Optional feature macro: ENCODER_RANGE_CHECK_EN (reject immediates that do
// not fit their field; default build truncates silently).
// Ports:
//   clk, rst_n (async, active-low)    start     -- begin a run
//   in_valid/in_ready/in_last         -- bundle handshake
//   opcode, imm_sel, rd, rs1, rs2, funct3, funct7, imm -- decoded fields
//   imem_we, imem_addr, imem_wdata    -- registered IMEM write port
//   busy, done, err, word_cnt         -- run status
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256,
  parameter int          AW        = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     imm_sel,
  input  logic [4:0]                     rd,
  input  logic [4:0]                     rs1,
  input  logic [4:0]                     rs2,
  input  logic [2:0]                     funct3,
  input  logic [6:0]                     funct7,
  input  logic [31:0]                    imm,
  output logic                           imem_we,
  output logic [AW-1:0]                  imem_addr,
  output logic [31:0]                    imem_wdata,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(DEPTH+1)-1:0]     word_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [CW:0] DEPTH_M1 = (CW + 1)'(DEPTH - 1);

  state_e          state_q;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [AW-1:0]   nxt_addr_q, nxt_addr_d;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            we_q;
  logic            err_q;

  logic [31:0]     pack_word;
  logic            reject;
  logic [CW:0]     occ;
  logic            accept;
  logic            wr;
  logic            fills;

  instr_pack u_pack (
    .opcode_i (opcode),
    .imm_sel_i(imm_sel),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .imm_i    (imm),
    .word_o   (pack_word),
    .reject_o (reject)
  );

  // Occupancy counts retired words plus the one sitting in the output
  // register, so the run never over-commits past DEPTH.
  assign occ      = {1'b0, word_cnt_q} + {{CW{1'b0}}, we_q};
  assign in_ready = (state_q == ST_RUN) && (occ < DEPTH_W);
  assign accept   = in_valid && in_ready;
  assign wr       = accept && !reject;
  assign fills    = wr && (occ == DEPTH_M1);

  // word_cnt advances when a write retires (the cycle imem_we is high).
  assign word_cnt_d = we_q ? (word_cnt_q + CW'(1)) : word_cnt_q;
  assign nxt_addr_d = wr ? (nxt_addr_q + AW'(4)) : nxt_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      nxt_addr_q <= AW'(BASE_ADDR);
      addr_q     <= AW'(BASE_ADDR);
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q       <= wr;
      word_cnt_q <= word_cnt_d;
      nxt_addr_q <= nxt_addr_d;
      if (wr) begin
        addr_q  <= nxt_addr_q;
        wdata_q <= pack_word;
      end
      if (accept && reject) err_q <= 1'b1;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          // No write can be pending here, so the clears below never race
          // a retiring word.
          if (start) begin
            state_q    <= ST_RUN;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            nxt_addr_q <= AW'(BASE_ADDR);
          end
        end
        ST_RUN: begin
          if (accept && (in_last || fills)) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // At most one word is pending and it retires on this edge.
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  imm_sel = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic          in_ready, imem_we, busy, done, err;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  instruction_encoder #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .imm_sel(imm_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_enc(input logic [2:0] s, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] v);
    logic [31:0] rdw, r1, r2, f3w, f7w, opw;
    rdw = 32'(d) << 7;  r1 = 32'(a) << 15; r2 = 32'(b) << 20;
    f3w = 32'(f3) << 12; f7w = 32'(f7) << 25; opw = 32'(op);
    case (s)
      3'd0: return ((v & 32'hFFF) << 20) | r1 | f3w | rdw | opw;
      3'd1: return (((v >> 5) & 32'h7F) << 25) | r2 | r1 | f3w | ((v & 32'h1F) << 7) | opw;
      3'd2: return (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) | r2 | r1 | f3w
                   | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7) | opw;
      3'd3: return (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                   | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12) | rdw | opw;
      3'd4: return (v & 32'hFFFFF000) | rdw | opw;
      3'd5: return f7w | r2 | r1 | f3w | rdw | opw;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_rej(input logic [2:0] s, input logic [31:0] v);
    int sv;
    sv = $signed(v);
    if (s > 3'd5) return 1'b1;
`ifdef ENCODER_RANGE_CHECK_EN
    case (s)
      3'd0, 3'd1: return !(sv >= -2048 && sv <= 2047);
      3'd2: return !(sv >= -4096 && sv <= 4095) || v[0];
      3'd3: return !(sv >= -1048576 && sv <= 1048575) || v[0];
      3'd4: return v[11:0] != 12'h0;
      default: return 1'b0;
    endcase
`else
    return (sv != sv) ? 1'b1 : 1'b0;
`endif
  endfunction

  // Model state: 0 idle, 1 running, 2 flushing, 3 done.
  int          m_st = 0;
  int          m_cnt = 0;
  bit          m_we = 0;
  bit          m_err = 0;
  logic [31:0] m_addr = 0, m_data = 0, m_next = 0;
  bit          m_acc, m_rj;
  int          m_occ;

  function automatic bit m_ready();
    return (m_st == 1) && ((m_cnt + int'(m_we)) < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_we = 0; m_err = 0;
      m_addr = 0; m_data = 0; m_next = 0;
    end else begin
      m_occ = m_cnt + int'(m_we);
      m_acc = in_valid && m_ready();
      m_rj  = m_acc && m_rej(imm_sel, imm);
      m_cnt = m_cnt + int'(m_we);
      m_we  = 0;
      if (m_acc && !m_rj) begin
        m_we   = 1;
        m_addr = m_next;
        m_data = m_enc(imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm);
        m_next = m_next + 4;
      end
      if (m_rj) m_err = 1;
      case (m_st)
        0, 3: if (start) begin m_st = 1; m_cnt = 0; m_err = 0; m_next = 0; end
        1: if (m_acc && (in_last || (!m_rj && m_occ + 1 == DEPTH))) m_st = 2;
        2: m_st = 3;
        default: m_st = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          chk_en = 0;
  logic [63:0] got_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("imem_we", imem_we, m_we);
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_data);
      chk1("in_ready", in_ready, m_ready());
      chk1("busy", busy, (m_st == 1) || (m_st == 2));
      chk1("done", done, m_st == 3);
      chk1("err", err, m_err);
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      if (imem_we) got_q.push_back({imem_addr, imem_wdata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] v, input logic last, input int maxwait, output bit ok);
    @(negedge clk);
    imm_sel = s; opcode = op; rd = d; rs1 = a; rs2 = b;
    funct3 = f3; funct7 = f7; imm = v; in_last = last; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < maxwait; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk1({name, "_done_reached"}, seen, 1'b1);
  endtask

  task automatic chk_w(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < got_q.size()) begin
      chk({name, "_addr"}, got_q[idx][63:32], a);
      chk({name, "_data"}, got_q[idx][31:0], d);
    end else begin
      chk({name, "_present"}, 32'(got_q.size()), 32'(idx + 1));
    end
  endtask

  bit ok;

  initial begin
    // Model pins: hand-encoded words from the instruction listing.
    chk("model_addi", m_enc(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 32'h00500093);
    chk("model_beq", m_enc(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC), 32'hFE000EE3);
    chk("model_auipc", m_enc(3'd4, 7'b0010111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), 32'h12345297);

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk1("rst_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_cnt", 32'(word_cnt), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Run A: addi, sw, beq(last) back-to-back.
    got_q.delete();
    pulse_start();
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 12, ok);
    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 12, ok);
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 12, ok);
    idle();
    wait_done("A");
    chk("A_nwrites", 32'(got_q.size()), 32'd3);
    chk_w("A0", 0, 32'h0, 32'h00500093);
    chk_w("A1", 1, 32'h4, 32'h0020A423);
    chk_w("A2", 2, 32'h8, 32'hFE000EE3);
    chk("A_word_cnt", 32'(word_cnt), 32'd3);

    // Run B: six bundles, no in_last; DEPTH=4 stops the run.
    got_q.delete();
    pulse_start();
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 12, ok);
    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 12, ok);
    send(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 12, ok);
    send(3'd4, 7'b0010111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 12, ok);
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 6, ok);
    chk1("B_5th_not_accepted", ok, 1'b0);
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 4, ok);
    chk1("B_6th_not_accepted", ok, 1'b0);
    idle();
    wait_done("B");
    chk("B_nwrites", 32'(got_q.size()), 32'd4);
    chk_w("B0", 0, 32'h0, 32'h00500093);
    chk_w("B1", 1, 32'h4, 32'h0020A423);
    chk_w("B2", 2, 32'h8, 32'h008000EF);
    chk_w("B3", 3, 32'hC, 32'h12345297);
    chk("B_word_cnt", 32'(word_cnt), 32'd4);
    chk1("B_ready_low", in_ready, 1'b0);

    // Run C: addi with imm 4096, then add x3,x1,x2 (last).
    got_q.delete();
    pulse_start();
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 12, ok);
    send(3'd5, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 12, ok);
    idle();
    wait_done("C");
`ifdef ENCODER_RANGE_CHECK_EN
    chk("C_nwrites", 32'(got_q.size()), 32'd1);
    chk_w("C0", 0, 32'h0, 32'h002081B3);
    chk1("C_err", err, 1'b1);
`else
    chk("C_nwrites", 32'(got_q.size()), 32'd2);
    chk_w("C0", 0, 32'h0, 32'h00000093);
    chk_w("C1", 1, 32'h4, 32'h002081B3);
    chk1("C_err", err, 1'b0);
`endif

    // Run D: start again while running (ignored), then illegal imm_sel with last.
    got_q.delete();
    pulse_start();
    pulse_start();
    send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 12, ok);
    idle();
    wait_done("D");
    chk("D_nwrites", 32'(got_q.size()), 32'd0);
    chk1("D_err", err, 1'b1);
    chk("D_word_cnt", 32'(word_cnt), 32'd0);

    // Run E: reset asserted while a write is pending.
    pulse_start();
    chk1("E_err_cleared", err, 1'b0);
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 12, ok);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("E_we_aborted", imem_we, 1'b0);
    chk("E_addr", imem_addr, 32'h0);
    chk("E_wdata", imem_wdata, 32'h0);
    chk1("E_busy", busy, 1'b0);
    chk1("E_ready", in_ready, 1'b0);
    chk("E_cnt", 32'(word_cnt), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Run F: normal run after reset.
    got_q.delete();
    pulse_start();
    send(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 12, ok);
    idle();
    wait_done("F");
    chk("F_nwrites", 32'(got_q.size()), 32'd1);
    chk_w("F0", 0, 32'h0, 32'h008000EF);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
